// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a registered add/sub/compare result and an iterative shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SEQ = 4'd2, OP_SNE = 4'd3,
                         OP_SLT = 4'd4, OP_SGT = 4'd5, OP_SLE = 4'd6, OP_MUL = 4'd8;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state;
  logic [WIDTH-1:0] mcand, mplier, acc, sum, diff, res;
  logic [CW-1:0] cnt;
  logic free, accept, load, ovf_add, ovf_sub, lt, eq, cmp, res_ovf, res_ill;
  always_comb begin
    free = !out_valid || out_ready;
    in_ready = (state == IDLE) && free;
    accept = in_valid && in_ready;
    sum = a + b;
    diff = a + ~b + WIDTH'(1);
    ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // overflow-corrected sign keeps signed compares right when a - b wraps
    lt = diff[WIDTH-1] ^ ovf_sub;
    eq = diff == '0;
    cmp = op == OP_SEQ ? eq :
          op == OP_SNE ? !eq :
          op == OP_SLT ? lt :
          op == OP_SGT ? (!lt && !eq) :
          op == OP_SLE ? (lt || eq) : !lt;
    res = state == DONE ? acc :
          op == OP_ADD ? sum :
          op == OP_SUB ? diff :
          op < OP_MUL  ? {{(WIDTH-1){1'b0}}, cmp} : '0;
    res_ovf = (state == IDLE) && (op == OP_ADD ? ovf_add : op == OP_SUB ? ovf_sub : 1'b0);
    res_ill = (state == IDLE) && (op > OP_MUL);
    load = (accept && op != OP_MUL) || (state == DONE && free);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      ovf <= 1'b0;
      illegal <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      if (load) begin
        result <= res;
        ovf <= res_ovf;
        illegal <= res_ill;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && op == OP_MUL) begin
        mcand <= a;
        mplier <= b;
        acc <= '0;
        cnt <= '0;
        state <= MUL;
      end else if (state == MUL) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) state <= DONE;
      end else if (state == DONE && free) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe with a behavioural reference model
module tb_alu_pipe;
  localparam int W = 32;
  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, ovf, illegal;
  logic [3:0] op = '0;
  logic [W-1:0] a = '0, b = '0, result;
  logic [W+1:0] sb[$];
  logic [W+1:0] held = '0;
  logic stalled = 0;
  bit bg_done = 0;
  int npass = 0, ntot = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W+1:0] model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y);
    longint sx, sy, s;
    logic c;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0;
    case (o)
      4'd0: begin s = sx + sy; return {1'b0, s > MAXV || s < MINV, W'(s)}; end
      4'd1: begin s = sx - sy; return {1'b0, s > MAXV || s < MINV, W'(s)}; end
      4'd2: c = sx == sy;
      4'd3: c = sx != sy;
      4'd4: c = sx < sy;
      4'd5: c = sx > sy;
      4'd6: c = sx <= sy;
      4'd7: c = sx >= sy;
      4'd8: return {2'b00, x * y};
      default: return {2'b10, {W{1'b0}}};
    endcase
    return {2'b00, {(W-1){1'b0}}, c};
  endfunction

  // Inputs are set on a falling edge; the transfer happens on the following rising edge.
  task automatic send(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, bit push = 1);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 0;
      return;
    end
    if (push) sb.push_back(model(o, x, y));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic wait_valid(output int e);
    e = 0;
    while (!out_valid && e < 100) begin
      @(posedge clk); #1; e++;
      if (e == 1) chk("mul_busy_ready", in_ready, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) chk("hold_stable", {illegal, ovf, result}, held);
      if (out_valid && !out_ready) chk("ready_low_when_full", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_output", out_valid, 0);
        else chk("result", {illegal, ovf, result}, sb.pop_front());
      end
      stalled <= out_valid && !out_ready;
      held <= {illegal, ovf, result};
    end else stalled <= 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e, seen;
    logic [3:0] cops[7] = '{4'd4, 4'd5, 4'd7, 4'd3, 4'd2, 4'd6, 4'd4};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {ovf, illegal}, 0);
    send(4'd0, 32'h7FFF_FFFF, 32'h1);
    in_valid = 0;
    chk("add_latency", out_valid, 1);
    chk("add_ovf_result", {ovf, result}, {1'b1, 32'h8000_0000});
    drain();
    for (int i = 0; i < 7; i++)
      send(cops[i], i < 4 ? 32'h8000_0000 : 32'h5, i < 4 ? 32'h1 : 32'h5);
    in_valid = 0;
    drain();
    fork
      begin
        for (int i = 0; i < 8; i++) send(4'd1, $urandom, $urandom);
        in_valid = 0;
      end
      begin
        int n = 0;
        do @(negedge clk); while (!out_valid && n++ < 20);
        for (int i = 0; i < 8; i++) begin
          chk("stream_valid", out_valid, 1);
          @(negedge clk);
        end
        chk("stream_drained", out_valid, 0);
      end
    join
    drain();
    bg_done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(4'd1, $urandom, $urandom);
        in_valid = 0;
        drain();
        bg_done = 1;
      end
      begin
        int k = 0;
        while (!bg_done) begin @(posedge clk); #1; out_ready = (k % 3 == 0); k++; end
        out_ready = 1;
      end
    join
    send(4'd8, 32'hFFFF_FFFF, 32'h3);
    in_valid = 0;
    wait_valid(e);
    chk("mul_latency", e, 33);
    chk("mul_result", result, 32'hFFFF_FFFD);
    drain();
    out_ready = 0;
    send(4'd8, $urandom, $urandom);
    in_valid = 0;
    wait_valid(e);
    chk("mul_stall_latency", e, 33);
    repeat (3) begin @(negedge clk); chk("mul_held_busy", in_ready, 0); end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    chk("mul_post_drain_ready", in_ready, 1);
    chk("mul_post_drain_valid", out_valid, 0);
    chk("mul_stall_drained", sb.size(), 0);
    send(4'd12, $urandom, $urandom);
    in_valid = 0;
    chk("illegal_out", {out_valid, illegal, ovf, result}, {3'b110, 32'h0});
    drain();
    send(4'd8, 32'h1234, 32'h5678, 0);
    in_valid = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #6 rst_n = 1;
    seen = 0;
    repeat (40) begin @(negedge clk); seen += int'(out_valid); end
    chk("abort_no_output", seen, 0);
    chk("abort_idle_ready", in_ready, 1);
    send(4'd0, 32'd100, 32'd23);
    in_valid = 0;
    chk("abort_next_add", {out_valid, result}, {1'b1, 32'd123});
    drain();
    bg_done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(4'($urandom_range(0, 15)), i % 5 == 0 ? 32'h8000_0000 : $urandom, $urandom);
        in_valid = 0;
        drain();
        bg_done = 1;
      end
      begin
        while (!bg_done) begin @(posedge clk); #1; out_ready = $urandom_range(0, 3) != 0; end
        out_ready = 1;
      end
    join
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
